// File: rtl/branch_resolve_pkg.sv
// branch_resolve_pkg: shared encodings and widths for the branch resolution unit
package branch_resolve_pkg;
  localparam int XLEN = 32;
  localparam int JIDX_W = 26;
  localparam int CNT_W = 3;
  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BEQ  = 3'd1,
    BR_BNE  = 3'd2,
    BR_BLEZ = 3'd3,
    BR_BGTZ = 3'd4,
    BR_BLTZ = 3'd5,
    BR_BGEZ = 3'd6,
    BR_J    = 3'd7
  } br_type_e;
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;
endpackage

// File: rtl/branch_resolve_if.sv
// branch_resolve_if: EX-side inputs and IF-side redirect/flush outputs; BRANCH_STATS_EN adds counters
interface branch_resolve_if;
  import branch_resolve_pkg::*;
  logic              stall_i;
  logic              valid_i;
  logic [2:0]        br_type_i;
  logic              zero_i;
  logic              neg_i;
  logic [XLEN-1:0]   pc_plus4_i;
  logic [XLEN-1:0]   imm_i;
  logic [JIDX_W-1:0] jidx_i;
  logic              redirect_o;
  logic [XLEN-1:0]   redirect_pc_o;
  logic              flush_o;
  logic              taken_o;
`ifdef BRANCH_STATS_EN
  logic [XLEN-1:0]   stat_resolved_o;
  logic [XLEN-1:0]   stat_taken_o;
  modport master (
    output stall_i, valid_i, br_type_i, zero_i, neg_i, pc_plus4_i, imm_i, jidx_i,
    input  redirect_o, redirect_pc_o, flush_o, taken_o, stat_resolved_o, stat_taken_o
  );
  modport slave (
    input  stall_i, valid_i, br_type_i, zero_i, neg_i, pc_plus4_i, imm_i, jidx_i,
    output redirect_o, redirect_pc_o, flush_o, taken_o, stat_resolved_o, stat_taken_o
  );
`else
  modport master (
    output stall_i, valid_i, br_type_i, zero_i, neg_i, pc_plus4_i, imm_i, jidx_i,
    input  redirect_o, redirect_pc_o, flush_o, taken_o
  );
  modport slave (
    input  stall_i, valid_i, br_type_i, zero_i, neg_i, pc_plus4_i, imm_i, jidx_i,
    output redirect_o, redirect_pc_o, flush_o, taken_o
  );
`endif
endinterface

// File: rtl/branch_cond.sv
// branch_cond: combinational branch condition and target from subtractor flags
module branch_cond
  import branch_resolve_pkg::*;
(
  input  logic [2:0]        br_type,
  input  logic              zero,
  input  logic              neg,
  input  logic [XLEN-1:0]   pc_plus4,
  input  logic [XLEN-1:0]   imm,
  input  logic [JIDX_W-1:0] jidx,
  output logic              cond,
  output logic [XLEN-1:0]   target
);
  logic [7:0] tbl;
  // indexed by br_type: J, BGEZ, BLTZ, BGTZ, BLEZ, BNE, BEQ, NONE
  assign tbl = {1'b1, !neg, neg, !zero && !neg, zero || neg, !zero, zero, 1'b0};
  assign cond = tbl[br_type];
  assign target = (br_type == BR_J) ? {pc_plus4[31:28], jidx, 2'b00} : pc_plus4 + (imm << 2);
endmodule

// File: rtl/branch_resolve.sv
// branch_resolve: EX-stage branch outcome, registered PC redirect and flush sequencing; BRANCH_STATS_EN adds resolve/taken counters
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int              FLUSH_CYCLES = 2,
  parameter logic [XLEN-1:0] PC_RESET     = 32'h0000_0000
) (
  input  logic clk,
  input  logic rst_n,
  branch_resolve_if.slave bus
);
  logic            cond;
  logic [XLEN-1:0] target;
  logic            resolve;
  state_e          st, st_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic            redirect, redirect_n, flush, flush_n, taken, taken_n;
  logic [XLEN-1:0] pc, pc_n;
  branch_cond u_cond (
    .br_type (bus.br_type_i),
    .zero    (bus.zero_i),
    .neg     (bus.neg_i),
    .pc_plus4(bus.pc_plus4_i),
    .imm     (bus.imm_i),
    .jidx    (bus.jidx_i),
    .cond    (cond),
    .target  (target)
  );
  assign resolve = bus.valid_i && !bus.stall_i && st == ST_IDLE && bus.br_type_i != BR_NONE;
  always_comb begin
    st_n = st;
    cnt_n = cnt;
    redirect_n = redirect;
    flush_n = flush;
    taken_n = taken;
    pc_n = pc;
    if (!bus.stall_i && st == ST_IDLE) begin
      redirect_n = 1'b0;
      flush_n = 1'b0;
      if (resolve) begin
        taken_n = cond;
        if (cond) begin
          redirect_n = 1'b1;
          pc_n = target;
          flush_n = 1'b1;
          cnt_n = CNT_W'(FLUSH_CYCLES - 1);
          st_n = ST_FLUSH;
        end
      end
    end else if (!bus.stall_i) begin
      redirect_n = 1'b0;
      st_n = (cnt == '0) ? ST_IDLE : ST_FLUSH;
      flush_n = (cnt != '0);
      cnt_n = (cnt == '0) ? cnt : cnt - 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= ST_IDLE;
      cnt <= '0;
      redirect <= 1'b0;
      flush <= 1'b0;
      taken <= 1'b0;
      pc <= PC_RESET;
    end else begin
      st <= st_n;
      cnt <= cnt_n;
      redirect <= redirect_n;
      flush <= flush_n;
      taken <= taken_n;
      pc <= pc_n;
    end
  end
  assign bus.redirect_o = redirect;
  assign bus.redirect_pc_o = pc;
  assign bus.flush_o = flush;
  assign bus.taken_o = taken;
`ifdef BRANCH_STATS_EN
  logic [XLEN-1:0] n_res, n_tk;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_res <= '0;
      n_tk <= '0;
    end else if (resolve) begin
      n_res <= (&n_res) ? n_res : n_res + 1'b1;
      n_tk <= (cond && !(&n_tk)) ? n_tk + 1'b1 : n_tk;
    end
  end
  assign bus.stat_resolved_o = n_res;
  assign bus.stat_taken_o = n_tk;
`endif
endmodule

// File: tb/tb_branch_resolve.sv
// tb_branch_resolve: directed and randomized checks of branch_resolve against a cycle-level reference model
module tb_branch_resolve;
  localparam int FC = 2;
  localparam logic [31:0] PCR = 32'h0000_0000;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  branch_resolve_if bus();
  branch_resolve #(.FLUSH_CYCLES(FC), .PC_RESET(PCR)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int errors = 0;
  int checks = 0;
  logic m_redirect, m_taken;
  logic [31:0] m_pc;
  int busy;
  int m_res, m_tk;

  function automatic logic ref_cond(input logic [2:0] t, input logic z, input logic n);
    case (t)
      3'd1: return z;
      3'd2: return !z;
      3'd3: return z || n;
      3'd4: return !z && !n;
      3'd5: return n;
      3'd6: return !n;
      3'd7: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_target(input logic [2:0] t, input logic [31:0] pc4,
                                             input logic [31:0] imm, input logic [25:0] j);
    logic [31:0] jj;
    jj = 32'(j);
    if (t == 3'd7) return (pc4 & 32'hF000_0000) | (jj * 32'd4);
    return pc4 + imm * 32'd4;
  endfunction

  task automatic model_reset();
    m_redirect = 1'b0;
    m_taken = 1'b0;
    m_pc = PCR;
    busy = 0;
    m_res = 0;
    m_tk = 0;
  endtask

  // busy counts unstalled cycles of flush still owed; any branch seen meanwhile is wrong-path
  task automatic cycle(input logic v, input logic [2:0] t, input logic z, input logic n,
                       input logic [31:0] pc4, input logic [31:0] imm, input logic [25:0] j,
                       input logic s);
    bus.valid_i = v;
    bus.br_type_i = t;
    bus.zero_i = z;
    bus.neg_i = n;
    bus.pc_plus4_i = pc4;
    bus.imm_i = imm;
    bus.jidx_i = j;
    bus.stall_i = s;
    @(posedge clk);
    if (!s) begin
      if (busy > 0) begin
        busy--;
        m_redirect = 1'b0;
      end else if (v && t != 3'd0) begin
        m_res++;
        m_taken = ref_cond(t, z, n);
        if (m_taken) begin
          m_tk++;
          m_redirect = 1'b1;
          m_pc = ref_target(t, pc4, imm, j);
          busy = FC;
        end
      end
    end
    #1;
  endtask

  task automatic idle(input logic s);
    cycle(1'b0, 3'd0, 1'b0, 1'b0, 32'h0, 32'h0, 26'h0, s);
  endtask

  task automatic test_reset();
    model_reset();
    #1;
    checks++;
    if ({bus.redirect_o, bus.flush_o, bus.taken_o, bus.redirect_pc_o} !== {3'b000, PCR}) begin
      errors++;
      $display("FAIL reset: got r=%b f=%b t=%b pc=%h want 0 0 0 %h", bus.redirect_o, bus.flush_o, bus.taken_o, bus.redirect_pc_o, PCR);
    end
    #2 rst_n = 1'b1;
    idle(1'b0);
    checks++;
    if ({bus.redirect_o, bus.flush_o, bus.taken_o} !== 3'b000) begin
      errors++;
      $display("FAIL reset_idle: got r=%b f=%b t=%b want 000", bus.redirect_o, bus.flush_o, bus.taken_o);
    end
  endtask

  task automatic test_beq();
    logic [2:0] want [3];
    want = '{3'b111, 3'b011, 3'b001};
    cycle(1'b1, 3'd1, 1'b1, 1'b0, 32'h0000_0104, 32'h0000_0003, 26'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) idle(1'b0);
      checks++;
      if ({bus.redirect_o, bus.flush_o, bus.taken_o} !== want[i] || bus.redirect_pc_o !== 32'h0000_0110) begin
        errors++;
        $display("FAIL beq[%0d]: got r/f/t=%b pc=%h want %b pc=00000110", i, {bus.redirect_o, bus.flush_o, bus.taken_o}, bus.redirect_pc_o, want[i]);
      end
    end
  endtask

  task automatic test_bne_not_taken();
    cycle(1'b1, 3'd2, 1'b1, 1'b0, 32'h0000_0200, 32'h0000_0010, 26'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) idle(1'b0);
      checks++;
      if ({bus.redirect_o, bus.flush_o, bus.taken_o} !== 3'b000) begin
        errors++;
        $display("FAIL bne[%0d]: got r/f/t=%b want 000", i, {bus.redirect_o, bus.flush_o, bus.taken_o});
      end
    end
  endtask

  task automatic test_bltz_squash();
    cycle(1'b1, 3'd5, 1'b0, 1'b1, 32'h0000_0004, 32'hFFFF_FFFF, 26'h0, 1'b0);
    checks++;
    if (bus.redirect_o !== 1'b1 || bus.redirect_pc_o !== 32'h0000_0000) begin
      errors++;
      $display("FAIL bltz: got r=%b pc=%h want 1 00000000", bus.redirect_o, bus.redirect_pc_o);
    end
    cycle(1'b1, 3'd6, 1'b0, 1'b0, 32'h0000_1000, 32'h0000_0040, 26'h0, 1'b0);
    checks++;
    if ({bus.redirect_o, bus.flush_o, bus.taken_o} !== 3'b011 || bus.redirect_pc_o !== 32'h0000_0000) begin
      errors++;
      $display("FAIL squash: got r/f/t=%b pc=%h want 011 00000000", {bus.redirect_o, bus.flush_o, bus.taken_o}, bus.redirect_pc_o);
    end
    idle(1'b0);
    idle(1'b0);
    checks++;
    if ({bus.redirect_o, bus.flush_o} !== 2'b00) begin
      errors++;
      $display("FAIL squash_end: got r/f=%b want 00", {bus.redirect_o, bus.flush_o});
    end
  endtask

  task automatic test_jump();
    cycle(1'b1, 3'd7, 1'b0, 1'b0, 32'hA000_0000, 32'h0, 26'h000_0040, 1'b0);
    checks++;
    if (bus.redirect_o !== 1'b1 || bus.redirect_pc_o !== 32'hA000_0100 || bus.taken_o !== 1'b1) begin
      errors++;
      $display("FAIL jump: got r=%b t=%b pc=%h want 1 1 a0000100", bus.redirect_o, bus.taken_o, bus.redirect_pc_o);
    end
    idle(1'b0);
    idle(1'b0);
  endtask

  task automatic test_stall();
    logic [1:0] want [6];
    want = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b01, 2'b00};
    cycle(1'b1, 3'd1, 1'b1, 1'b0, 32'h0000_0800, 32'h0000_0020, 26'h0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      if (i > 0 && i < 4) cycle(1'b1, 3'd7, 1'b0, 1'b0, 32'h5000_0000, 32'h0, 26'h3, 1'b1);
      else if (i >= 4) idle(1'b0);
      checks++;
      if ({bus.redirect_o, bus.flush_o} !== want[i] || bus.redirect_pc_o !== 32'h0000_0880) begin
        errors++;
        $display("FAIL stall[%0d]: got r/f=%b pc=%h want %b 00000880", i, {bus.redirect_o, bus.flush_o}, bus.redirect_pc_o, want[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    cycle(1'b1, 3'd4, 1'b0, 1'b0, 32'h0000_0100, 32'h0000_0001, 26'h0, 1'b0);
    idle(1'b0);
    idle(1'b0);
    cycle(1'b1, 3'd3, 1'b1, 1'b0, 32'h0000_0300, 32'hFFFF_FFFE, 26'h0, 1'b0);
    checks++;
    if ({bus.redirect_o, bus.flush_o, bus.taken_o} !== 3'b111 || bus.redirect_pc_o !== 32'h0000_02F8) begin
      errors++;
      $display("FAIL back_to_back: got r/f/t=%b pc=%h want 111 000002f8", {bus.redirect_o, bus.flush_o, bus.taken_o}, bus.redirect_pc_o);
    end
    idle(1'b0);
    idle(1'b0);
  endtask

  task automatic test_reset_mid_flush();
    cycle(1'b1, 3'd1, 1'b1, 1'b0, 32'h0000_4000, 32'h0000_0100, 26'h0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({bus.redirect_o, bus.flush_o, bus.taken_o, bus.redirect_pc_o} !== {3'b000, PCR}) begin
      errors++;
      $display("FAIL async_reset: got r/f/t=%b pc=%h want 000 %h", {bus.redirect_o, bus.flush_o, bus.taken_o}, bus.redirect_pc_o, PCR);
    end
    #2 rst_n = 1'b1;
    idle(1'b0);
    checks++;
    if ({bus.redirect_o, bus.flush_o, bus.taken_o} !== 3'b000) begin
      errors++;
      $display("FAIL residual_flush: got r/f/t=%b want 000", {bus.redirect_o, bus.flush_o, bus.taken_o});
    end
    cycle(1'b1, 3'd2, 1'b0, 1'b0, 32'h0000_0040, 32'h0000_0004, 26'h0, 1'b0);
    checks++;
    if ({bus.redirect_o, bus.flush_o, bus.taken_o} !== 3'b111 || bus.redirect_pc_o !== 32'h0000_0050) begin
      errors++;
      $display("FAIL post_reset: got r/f/t=%b pc=%h want 111 00000050", {bus.redirect_o, bus.flush_o, bus.taken_o}, bus.redirect_pc_o);
    end
    idle(1'b0);
    idle(1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 9) < 8), 3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
            $urandom, ($urandom_range(0, 1) == 1) ? 32'hFFFF_0000 | 32'($urandom_range(0, 65535)) : 32'($urandom_range(0, 65535)),
            26'($urandom), ($urandom_range(0, 4) == 0));
      checks++;
      if ({bus.redirect_o, bus.flush_o, bus.taken_o, bus.redirect_pc_o} !== {m_redirect, (busy > 0), m_taken, m_pc}) begin
        errors++;
        $display("FAIL random[%0d]: got r/f/t=%b pc=%h want %b pc=%h", i, {bus.redirect_o, bus.flush_o, bus.taken_o}, bus.redirect_pc_o, {m_redirect, (busy > 0), m_taken}, m_pc);
      end
    end
  endtask

`ifdef BRANCH_STATS_EN
  task automatic test_stats();
    checks++;
    if (bus.stat_resolved_o !== 32'(m_res) || bus.stat_taken_o !== 32'(m_tk)) begin
      errors++;
      $display("FAIL stats: got res=%0d tk=%0d want %0d %0d", bus.stat_resolved_o, bus.stat_taken_o, m_res, m_tk);
    end
  endtask
`endif

  initial begin
    bus.stall_i = 1'b0;
    bus.valid_i = 1'b0;
    bus.br_type_i = 3'd0;
    bus.zero_i = 1'b0;
    bus.neg_i = 1'b0;
    bus.pc_plus4_i = 32'h0;
    bus.imm_i = 32'h0;
    bus.jidx_i = 26'h0;
    test_reset();
    test_beq();
    test_bne_not_taken();
    test_bltz_squash();
    test_jump();
    test_stall();
    test_back_to_back();
    test_reset_mid_flush();
    test_random();
`ifdef BRANCH_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
- EX-stage branch resolution unit. Sits directly downstream of the EX subtractor and consumes its zero/neg flags.
- Decides branch/jump outcome and computes the target.
- Registers a one-cycle-latency PC redirect toward IF.
- Sequences the pipeline flush of younger wrong-path instructions, squashing any branch that arrives while a flush is in progress.

Parameters:
- FLUSH_CYCLES, 2, cycles flush_o stays asserted after a taken redirect (range 1..7).
- PC_RESET, 32'h0000_0000, reset value of redirect_pc_o.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- stall_i  input  1  pipeline hold; freezes all state and outputs.
- valid_i  input  1  EX holds a real (non-bubble) instruction.
- br_type_i  input  3  branch kind: 0 NONE, 1 BEQ, 2 BNE, 3 BLEZ, 4 BGTZ, 5 BLTZ, 6 BGEZ, 7 J.
- zero_i  input  1  subtractor result == 0.
- neg_i  input  1  subtractor result < 0 (signed).
- pc_plus4_i  input  32  PC+4 of the EX instruction.
- imm_i  input  32  sign-extended 16-bit offset for conditional branches.
- jidx_i  input  26  J-type instruction index.
- redirect_o  output  1  IF must load redirect_pc_o.
- redirect_pc_o  output  32  new fetch address.
- flush_o  output  1  squash IF/ID and ID/EX contents.
- taken_o  output  1  registered outcome of the last resolved branch (debug/hazard use).

Behaviour:
- Reset (async, rst_n=0): redirect_o=0, redirect_pc_o=PC_RESET, flush_o=0, taken_o=0, FSM=IDLE, flush counter=0.
- Condition (combinational, from the subtractor with data1=rs, data2=rt or 0):
  - BEQ: zero
  - BNE: !zero
  - BLEZ: zero|neg
  - BGTZ: !zero&!neg
  - BLTZ: neg
  - BGEZ: !neg
  - J: 1
  - NONE: 0
- Target arithmetic:
  - Conditional branches: pc_plus4_i + {imm_i[29:0],2'b00}, modulo 2^32 (wrap-around ignored, no trap).
  - J: {pc_plus4_i[31:28], jidx_i, 2'b00}.
- "Resolve" event: valid_i=1, stall_i=0, FSM=IDLE, br_type_i!=NONE.
  - On the next edge: taken_o=cond.
  - If cond=1: redirect_o=1, redirect_pc_o=target, flush_o=1, counter=FLUSH_CYCLES-1, FSM→FLUSH.
  - Latency: 1 cycle from the sampling edge.
- FSM states:
  - IDLE: redirect_o=0, flush_o=0 unless a taken branch resolves (see above).
  - FLUSH: redirect_o=0 after its first cycle. flush_o=1 while counter>0 or in the entry cycle. Each unstalled cycle the counter decrements; when it reaches 0 with stall_i=0, FSM→IDLE and flush_o=0 next cycle.
  - FLUSH_CYCLES=1: FLUSH lasts exactly one cycle.
- Squash: any valid_i branch presented while FSM=FLUSH is wrong-path. It is ignored, with no redirect and taken_o unchanged.
- Not-taken branch: taken_o=0, no redirect, no flush, FSM stays IDLE.
- Stall: stall_i=1 holds FSM, counter and all outputs, including a pending redirect_o=1, until stall_i=0. Inputs are not sampled.
- Back-to-back: a branch in the first IDLE cycle after FLUSH exits resolves normally.
- Reset mid-flush: all outputs drop to reset values immediately (async), with no residual flush after rst_n rises.

Optional Feature:
- BRANCH_STATS_EN defined: adds 32-bit output counters stat_resolved_o (resolve events) and stat_taken_o (taken resolves).
  - Both reset to 0 asynchronously, saturate at 32'hFFFF_FFFF and hold during stall.
- Not defined: counters and ports are absent; behaviour is otherwise identical.

Decomposition:
- Shared package/include: br_type encodings (BR_NONE..BR_J), FSM state encodings (ST_IDLE, ST_FLUSH), width constants.
- One natural sub-module, branch_cond: purely combinational condition + target computation. The top holds the FSM and registers.

Test Plan:
- BEQ, zero_i=1, pc_plus4_i=32'h0000_0104, imm_i=32'h0000_0003 → next cycle redirect_o=1, redirect_pc_o=32'h0000_0110, taken_o=1; flush_o high 2 cycles.
- BNE, zero_i=1 → taken_o=0, redirect_o=0, flush_o=0 for all cycles.
- BLTZ, neg_i=1, imm_i=32'hFFFF_FFFF, pc_plus4_i=32'h0000_0004 → redirect_pc_o=32'h0000_0000 (negative offset). A BGEZ with valid_i=1 in the following FLUSH cycle is squashed: no second redirect.
- J, jidx_i=26'h000_0040, pc_plus4_i=32'hA000_0000 → redirect_pc_o=32'hA000_0100.
- Taken BEQ, then stall_i=1 for 3 cycles in the first FLUSH cycle → redirect_o and flush_o held 3 extra cycles; total flush duration of 2 unstalled cycles is preserved.
- rst_n pulsed low during FLUSH → flush_o, redirect_o, taken_o drop to 0 asynchronously. The first branch after reset resolves normally.
